// File: rtl/msk_sym_sync.sv
// -----------------------------------------------------------------------------
// msk_sym_sync
//   Symbol timing recovery and decimation for the MSK receive chain. Takes the
//   matched-filter I/Q stream, picks one on-time sample per symbol with an
//   early-late gate on |I|+|Q|, slips the strobe by +/-1 sample when the timing
//   error accumulator crosses a threshold, and queues the on-time samples in a
//   small first-word-fall-through FIFO toward the demodulator.
//
//   Optional feature macro: MSK_SYM_SYNC_DBG_EN (adds dbg_ted / dbg_adj ports).
//
// Ports
//   clk      in   1   clock
//   rst      in   1   synchronous active-high reset
//   I_in     in  16   signed matched-filter I
//   Q_in     in  16   signed matched-filter Q
//   IQ_val   in   1   sample qualifier; only qualified samples advance timing
//   sym_I    out 16   signed on-time symbol I (FIFO head)
//   sym_Q    out 16   signed on-time symbol Q (FIFO head)
//   sym_val  out  1   FIFO head valid
//   sym_rdy  in   1   consumer ready; pop when sym_val && sym_rdy
//   locked   out  1   timing lock indicator
//   ovf      out  1   sticky: a symbol was dropped on a full FIFO
//   dbg_ted  out 18   (debug build) timing error of the last strobe
//   dbg_adj  out  2   (debug build) 1-cycle pulse: 01 advance, 10 retard
// -----------------------------------------------------------------------------
module msk_sym_sync #(
   parameter int SPS        = 8,
   parameter int ACC_W      = 20,
   parameter int THRESH     = 4096,
   parameter int LOCK_CNT   = 16,
   parameter int FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] I_in,
   input  logic [15:0] Q_in,
   input  logic        IQ_val,
   output logic [15:0] sym_I,
   output logic [15:0] sym_Q,
   output logic        sym_val,
   input  logic        sym_rdy,
   output logic        locked,
   output logic        ovf
`ifdef MSK_SYM_SYNC_DBG_EN
   ,
   output logic [17:0] dbg_ted,
   output logic [1:0]  dbg_adj
`endif
);

   localparam int CNT_W  = $clog2(SPS + 2);
   localparam int LCK_W  = $clog2(LOCK_CNT + 1);
   localparam int FCNT_W = $clog2(FIFO_DEPTH + 1);

   localparam logic [CNT_W-1:0]  PER_NOM   = CNT_W'(SPS);
   localparam logic [CNT_W-1:0]  PER_RET   = CNT_W'(SPS + 1);
   localparam logic [CNT_W-1:0]  PER_ADV   = CNT_W'(SPS - 1);
   localparam logic [LCK_W-1:0]  LOCK_MAX  = LCK_W'(LOCK_CNT);
   localparam logic [FCNT_W-1:0] FIFO_FULL = FCNT_W'(FIFO_DEPTH);

   localparam logic signed [ACC_W-1:0] THR_POS = ACC_W'(THRESH);
   localparam logic signed [ACC_W-1:0] THR_NEG = -THR_POS;
   // Symmetric saturation limits +/-(2^(ACC_W-1)-1), held one bit wider so the
   // raw sum can be compared before it is narrowed.
   localparam logic signed [ACC_W:0]   SUM_MAX = {2'b00, {(ACC_W-1){1'b1}}};
   localparam logic signed [ACC_W:0]   SUM_MIN = {2'b11, {(ACC_W-2){1'b0}}, 1'b1};
   localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-2){1'b0}}, 1'b1};

   // |I|+|Q| as 17-bit unsigned; |-32768| is represented exactly as 32768.
   function automatic logic [16:0] iq_mag(input logic [15:0] i_v, input logic [15:0] q_v);
      logic [16:0] ai;
      logic [16:0] aq;
      ai = i_v[15] ? (17'd0 - {i_v[15], i_v}) : {1'b0, i_v};
      aq = q_v[15] ? (17'd0 - {q_v[15], q_v}) : {1'b0, q_v};
      return ai + aq;
   endfunction

   // Timing state
   logic [CNT_W-1:0]        cnt_d, cnt_q;
   logic [CNT_W-1:0]        per_d, per_q;
   logic [31:0]             d0_d, d0_q;      // {I,Q} of previous qualified sample
   logic [31:0]             d1_d, d1_q;      // {I,Q} two samples back
   logic signed [ACC_W-1:0] acc_d, acc_q;
   logic [LCK_W-1:0]        lock_cnt_d, lock_cnt_q;
   logic                    locked_d, locked_q;
   logic                    wr_d, wr_q;      // pending FIFO write of on-time sample
   logic [31:0]             wdat_d, wdat_q;

   // FIFO state; entry 0 is the registered head presented on sym_I/sym_Q
   logic [31:0]             mem_d [FIFO_DEPTH];
   logic [31:0]             mem_q [FIFO_DEPTH];
   logic [31:0]             sh_s  [FIFO_DEPTH];
   logic [FCNT_W-1:0]       fcnt_d, fcnt_q;
   logic                    sym_val_d, sym_val_q;
   logic                    ovf_d, ovf_q;

   // Combinational helpers
   logic                    strobe_s;
   logic [16:0]             m_late_s;
   logic [16:0]             m_early_s;
   logic signed [17:0]      ted_s;
   logic signed [ACC_W:0]   acc_sum_s;
   logic signed [ACC_W-1:0] acc_post_s;
   logic                    pop_s;
   logic                    full_s;
   logic                    wr_ok_s;
   logic [FCNT_W-1:0]       widx_s;

   // Timing error detector, accumulator and strobe scheduling
   always_comb begin
      cnt_d      = cnt_q;
      per_d      = per_q;
      d0_d       = d0_q;
      d1_d       = d1_q;
      acc_d      = acc_q;
      lock_cnt_d = lock_cnt_q;
      wr_d       = 1'b0;
      wdat_d     = wdat_q;

      // Strobe sample: late = incoming, on-time = d0, early = d1.
      strobe_s  = IQ_val && (cnt_q == (per_q - CNT_W'(1)));
      m_late_s  = iq_mag(I_in, Q_in);
      m_early_s = iq_mag(d1_q[31:16], d1_q[15:0]);
      ted_s     = $signed({1'b0, m_late_s}) - $signed({1'b0, m_early_s});
      acc_sum_s = $signed({acc_q[ACC_W-1], acc_q}) + $signed({{(ACC_W-17){ted_s[17]}}, ted_s});

      if (acc_sum_s > SUM_MAX) begin
         acc_post_s = ACC_MAX;
      end else if (acc_sum_s < SUM_MIN) begin
         acc_post_s = ACC_MIN;
      end else begin
         acc_post_s = acc_sum_s[ACC_W-1:0];
      end

      if (IQ_val) begin
         d0_d = {I_in, Q_in};
         d1_d = d0_q;
         if (strobe_s) begin
            cnt_d  = '0;
            wr_d   = 1'b1;
            wdat_d = d0_q;
            // The decision only stretches or shortens the period that follows.
            if (acc_post_s > THR_POS) begin
               per_d      = PER_RET;
               acc_d      = '0;
               lock_cnt_d = '0;
            end else if (acc_post_s < THR_NEG) begin
               per_d      = PER_ADV;
               acc_d      = '0;
               lock_cnt_d = '0;
            end else begin
               per_d = PER_NOM;
               acc_d = acc_post_s;
               if (lock_cnt_q != LOCK_MAX) begin
                  lock_cnt_d = lock_cnt_q + LCK_W'(1);
               end else begin
                  lock_cnt_d = lock_cnt_q;
               end
            end
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end else begin
         cnt_d = cnt_q;
      end

      locked_d = (lock_cnt_d >= LOCK_MAX);
   end

   // Output FIFO: shift-down on pop, write lands behind the surviving entries
   always_comb begin
      pop_s   = sym_val_q && sym_rdy;
      full_s  = (fcnt_q == FIFO_FULL);
      wr_ok_s = wr_q && (!full_s || pop_s);
      widx_s  = pop_s ? (fcnt_q - FCNT_W'(1)) : fcnt_q;
      ovf_d   = ovf_q;

      for (int i = 0; i < FIFO_DEPTH; i++) begin
         sh_s[i] = mem_q[i];
      end
      if (pop_s) begin
         for (int i = 0; i < FIFO_DEPTH - 1; i++) begin
            sh_s[i] = mem_q[i + 1];
         end
      end else begin
         sh_s[0] = mem_q[0];
      end

      for (int i = 0; i < FIFO_DEPTH; i++) begin
         mem_d[i] = (wr_ok_s && (FCNT_W'(i) == widx_s)) ? wdat_q : sh_s[i];
      end

      case ({wr_ok_s, pop_s})
         2'b10:   fcnt_d = fcnt_q + FCNT_W'(1);
         2'b01:   fcnt_d = fcnt_q - FCNT_W'(1);
         default: fcnt_d = fcnt_q;
      endcase

      if (wr_q && full_s && !pop_s) begin
         ovf_d = 1'b1;
      end else begin
         ovf_d = ovf_q;
      end

      sym_val_d = (fcnt_d != '0);
   end

   // State registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q      <= '0;
         per_q      <= PER_NOM;
         d0_q       <= 32'd0;
         d1_q       <= 32'd0;
         acc_q      <= '0;
         lock_cnt_q <= '0;
         locked_q   <= 1'b0;
         wr_q       <= 1'b0;
         wdat_q     <= 32'd0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_q[i] <= 32'd0;
         end
         fcnt_q     <= '0;
         sym_val_q  <= 1'b0;
         ovf_q      <= 1'b0;
      end else begin
         cnt_q      <= cnt_d;
         per_q      <= per_d;
         d0_q       <= d0_d;
         d1_q       <= d1_d;
         acc_q      <= acc_d;
         lock_cnt_q <= lock_cnt_d;
         locked_q   <= locked_d;
         wr_q       <= wr_d;
         wdat_q     <= wdat_d;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_q[i] <= mem_d[i];
         end
         fcnt_q     <= fcnt_d;
         sym_val_q  <= sym_val_d;
         ovf_q      <= ovf_d;
      end
   end

   assign sym_I   = mem_q[0][31:16];
   assign sym_Q   = mem_q[0][15:0];
   assign sym_val = sym_val_q;
   assign locked  = locked_q;
   assign ovf     = ovf_q;

`ifdef MSK_SYM_SYNC_DBG_EN
   logic [17:0] dbg_ted_d, dbg_ted_q;
   logic [1:0]  dbg_adj_d, dbg_adj_q;

   // Debug capture of the strobe's timing error and adjustment direction
   always_comb begin
      dbg_ted_d = dbg_ted_q;
      dbg_adj_d = 2'b00;
      if (strobe_s) begin
         dbg_ted_d = ted_s;
         if (acc_post_s > THR_POS) begin
            dbg_adj_d = 2'b10;
         end else if (acc_post_s < THR_NEG) begin
            dbg_adj_d = 2'b01;
         end else begin
            dbg_adj_d = 2'b00;
         end
      end else begin
         dbg_adj_d = 2'b00;
      end
   end

   // Debug registers
   always_ff @(posedge clk) begin
      if (rst) begin
         dbg_ted_q <= 18'd0;
         dbg_adj_q <= 2'b00;
      end else begin
         dbg_ted_q <= dbg_ted_d;
         dbg_adj_q <= dbg_adj_d;
      end
   end

   assign dbg_ted = dbg_ted_q;
   assign dbg_adj = dbg_adj_q;
`endif

endmodule

// File: tb/tb_msk_sym_sync.sv
// -----------------------------------------------------------------------------
// tb_msk_sym_sync
//   Directed bench for msk_sym_sync (SPS=8, THRESH=4096, LOCK_CNT=16,
//   FIFO_DEPTH=4). A table of single-symbol vectors checks on-time selection
//   and latency; hand-written sequences cover lock, timing slips, FIFO
//   overflow, mid-stream reset and gapped input. A negedge monitor checks
//   every popped symbol against an expectation queue and records pop spacing.
// -----------------------------------------------------------------------------
module tb_msk_sym_sync;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] I_in, Q_in;
   logic        IQ_val;
   logic [15:0] sym_I, sym_Q;
   logic        sym_val;
   logic        sym_rdy;
   logic        locked;
   logic        ovf;
`ifdef MSK_SYM_SYNC_DBG_EN
   logic [17:0] dbg_ted;
   logic [1:0]  dbg_adj;
`endif

   msk_sym_sync dut (
      .clk     (clk),
      .rst     (rst),
      .I_in    (I_in),
      .Q_in    (Q_in),
      .IQ_val  (IQ_val),
      .sym_I   (sym_I),
      .sym_Q   (sym_Q),
      .sym_val (sym_val),
      .sym_rdy (sym_rdy),
      .locked  (locked),
      .ovf     (ovf)
`ifdef MSK_SYM_SYNC_DBG_EN
      ,
      .dbg_ted (dbg_ted),
      .dbg_adj (dbg_adj)
`endif
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   logic [31:0] exp_q[$];   // expected {sym_I,sym_Q} in pop order
   int          gap_q[$];   // cycles between consecutive pops
   int          last_pop = 0;
   bit          have_last = 1'b0;

   typedef struct {
      logic [15:0] on_i;
      logic [15:0] on_q;
      logic [15:0] side;   // I at samples 5 and 7 (early/late)
      logic [15:0] exp_i;
      logic [15:0] exp_q;
   } vec_t;

   vec_t vecs [6];

   // Cycle counter
   always @(posedge clk) cyc <= cyc + 1;

   // Pop monitor
   always @(negedge clk) begin
      if (sym_val && sym_rdy) begin
         checks = checks + 1;
         if (exp_q.size() == 0) begin
            errors = errors + 1;
            $display("FAIL unexpected_pop: got %0d/%0d required no symbol", $signed(sym_I), $signed(sym_Q));
         end else begin
            logic [31:0] e;
            e = exp_q.pop_front();
            if ({sym_I, sym_Q} !== e) begin
               errors = errors + 1;
               $display("FAIL sym_pop: got %0d/%0d required %0d/%0d", $signed(sym_I), $signed(sym_Q),
                        $signed(e[31:16]), $signed(e[15:0]));
            end
         end
         if (have_last) gap_q.push_back(cyc - last_pop);
         last_pop  = cyc;
         have_last = 1'b1;
      end
   end

   task automatic chk(input string name, input int act, input int req);
      checks = checks + 1;
      if (act !== req) begin
         errors = errors + 1;
         $display("FAIL %s: got %0d required %0d", name, act, req);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic smp(input logic [15:0] i, input logic [15:0] q);
      I_in   = i;
      Q_in   = q;
      IQ_val = 1'b1;
      tick();
      IQ_val = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      have_last = 1'b0;
      gap_q.delete();
   endtask

   task automatic wait_drain(input string name, input int budget);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         tick();
         n++;
      end
      tick();
      chk(name, exp_q.size(), 0);
      exp_q.delete();
   endtask

   // Triangle pulse: 500/peak/500 at symbol positions 5/6/7, shifted by sh samples.
   function automatic logic [15:0] tri_val(input int t, input int sh, input int peak);
      int u;
      u = t - sh;
      if (u < 0) return 16'd0;
      case (u % 8)
         5:       return 16'd500;
         6:       return 16'(peak);
         7:       return 16'd500;
         default: return 16'd0;
      endcase
   endfunction

   function automatic int count_not(input int v);
      int b;
      b = 0;
      foreach (gap_q[k]) if (gap_q[k] != v) b++;
      return b;
   endfunction

   // One strong sample at position pos: 7 is late (retard -> 9), 5 is early (advance -> 7).
   task automatic run_adj(input int pos, input int req_gap, input string name);
      do_reset();
      sym_rdy = 1'b1;
      exp_q.push_back(32'd0);
      exp_q.push_back(32'd0);
      for (int t = 0; t < 17; t++) begin
         if (t == pos) smp(16'h8000, 16'h8000);
         else          smp(16'd0, 16'd0);
      end
      wait_drain({name, "_drain"}, 8);
      chk({name, "_npops"}, gap_q.size(), 1);
      if (gap_q.size() > 0) chk({name, "_gap"}, gap_q[0], req_gap);
   endtask

   // Global time bound
   initial begin
      #2000000;
      $display("FAIL timeout: got no finish required finish");
      $fatal(1);
   end

   initial begin
      vecs[0] = '{16'd1000,   16'd0,      16'd500,  16'd1000,   16'd0};
      vecs[1] = '{16'hFC18,   16'd250,    16'd0,    16'hFC18,   16'd250};
      vecs[2] = '{16'h8000,   16'h8000,   16'd100,  16'h8000,   16'h8000};
      vecs[3] = '{16'h7FFF,   16'hFFFF,   16'd0,    16'h7FFF,   16'hFFFF};
      vecs[4] = '{16'd0,      16'd0,      16'd700,  16'd0,      16'd0};
      vecs[5] = '{16'd12345,  16'hFFCA,   16'hFED4, 16'd12345,  16'hFFCA};

      rst = 1'b1; I_in = 16'd1000; Q_in = 16'd1000; IQ_val = 1'b1; sym_rdy = 1'b1;

      // 1: reset held three cycles with qualified input
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("rst_outputs", int'({sym_I, sym_Q, sym_val, locked, ovf}), 0);
      end
      rst = 1'b0; IQ_val = 1'b0;

      // Table: one symbol each, on-time selection and N+2 latency
      foreach (vecs[r]) begin
         do_reset();
         exp_q.push_back({vecs[r].exp_i, vecs[r].exp_q});
         for (int t = 0; t < 8; t++) begin
            if (t == 6)                smp(vecs[r].on_i, vecs[r].on_q);
            else if (t == 5 || t == 7) smp(vecs[r].side, 16'd0);
            else                       smp(16'd0, 16'd0);
         end
         chk("lat_n1_val", int'(sym_val), 0);
         tick();
         chk("lat_n2_val", int'(sym_val), 1);
         wait_drain("vec_drain", 5);
      end

      // 2: centred triangle, lock after 16 symbols
      do_reset();
      repeat (20) exp_q.push_back({16'd1000, 16'd0});
      for (int t = 0; t < 160; t++) begin
         smp(tri_val(t, 0, 1000), 16'd0);
         if (t == 126) chk("s2_unlocked_15", int'(locked), 0);
         if (t == 127) chk("s2_locked_16", int'(locked), 1);
      end
      wait_drain("s2_drain", 6);
      chk("s2_period", count_not(8), 0);

      // 3: pulse one sample late -> one 9-sample period after 5th strobe
      do_reset();
      repeat (5)  exp_q.push_back({16'd500, 16'd0});
      repeat (15) exp_q.push_back({16'd1000, 16'd0});
      for (int t = 0; t <= 160; t++) smp(tri_val(t, 1, 1000), 16'd0);
      wait_drain("s3_drain", 6);
      chk("s3_ngaps", gap_q.size(), 19);
      if (gap_q.size() > 4) chk("s3_slip_gap", gap_q[4], 9);
      chk("s3_other_gaps", count_not(8) , 1);
      chk("s3_not_locked", int'(locked), 0);

      // Boundary: |-32768| magnitudes force immediate retard / advance
      run_adj(7, 9, "retard");
      run_adj(5, 7, "advance");

      // 4: consumer stalled for 6 symbols with a 4-deep FIFO
      do_reset();
      sym_rdy = 1'b0;
      for (int t = 0; t < 48; t++) begin
         if (t % 8 == 6) smp(16'(100 * (t / 8 + 1)), 16'd0);
         else            smp(tri_val(t, 0, 0), 16'd0);
         if (t == 32) chk("s4_ovf_at_full", int'(ovf), 0);
         if (t == 39) chk("s4_ovf_before_drop", int'(ovf), 0);
         if (t == 40) chk("s4_ovf_on_drop", int'(ovf), 1);
      end
      repeat (3) tick();
      chk("s4_head_held", int'(sym_I), 100);
      chk("s4_val_held", int'(sym_val), 1);
      for (int n = 1; n <= 4; n++) exp_q.push_back({16'(100 * n), 16'd0});
      sym_rdy = 1'b1;
      wait_drain("s4_drain", 10);
      repeat (3) tick();
      chk("s4_empty_after", int'(sym_val), 0);
      chk("s4_ovf_sticky", int'(ovf), 1);

      // 5: reset at cnt=3 with two symbols held
      do_reset();
      repeat (20) exp_q.push_back({16'd1000, 16'd0});
      for (int t = 0; t < 160; t++) smp(tri_val(t, 0, 1000), 16'd0);
      wait_drain("s5_pre_drain", 6);
      chk("s5_pre_locked", int'(locked), 1);
      sym_rdy = 1'b0;
      for (int t = 160; t < 179; t++) smp(tri_val(t, 0, 1000), 16'd0);
      chk("s5_fifo_held", int'(sym_val), 1);
      rst = 1'b1; IQ_val = 1'b1;
      tick();
      rst = 1'b0; IQ_val = 1'b0;
      have_last = 1'b0; gap_q.delete();
      chk("s5_rst_val", int'(sym_val), 0);
      chk("s5_rst_locked", int'(locked), 0);
      chk("s5_rst_ovf", int'(ovf), 0);
      sym_rdy = 1'b1;
      exp_q.push_back({16'd1000, 16'd0});
      for (int t = 0; t < 7; t++) smp(tri_val(t, 0, 1000), 16'd0);
      repeat (3) tick();
      chk("s5_no_early_strobe", exp_q.size(), 1);
      smp(tri_val(7, 0, 1000), 16'd0);
      wait_drain("s5_strobe_8th", 5);

      // 6: IQ_val every other cycle -> symbol every 16 clocks
      do_reset();
      repeat (6) exp_q.push_back({16'd1000, 16'd0});
      for (int t = 0; t < 48; t++) begin
         smp(tri_val(t, 0, 1000), 16'd0);
         tick();
      end
      wait_drain("s6_drain", 6);
      chk("s6_ngaps", gap_q.size(), 5);
      chk("s6_period16", count_not(16), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
